snd_capture_sched: RTL and testbench

- Synthesizable scheduler that samples the four APU channel DAC inputs at a fixed audio rate.
- Frames each sample set and serializes the frames into a byte stream in Sun AU (.snd) format, 32-byte header first.
- Sits between the APU channel outputs and a byte sink (bench file writer or debug UART). Stream content matches the sound-dump format the team already uses.

---
 rtl/snd_capture_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_snd_capture_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_capture_sched.sv
// Sun AU (.snd) capture scheduler: samples the APU channel DACs at a fixed rate and streams a
// 32-byte header followed by sample frames. Build option SND_CAPTURE_INT16_EN selects 16-bit samples.
module snd_capture_sched #(
    parameter int unsigned SAMPLE_DIV  = 95,
    parameter int unsigned SAMPLE_RATE = 44100,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] ch_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        hdr_done,
    output logic [15:0] overrun_cnt
);

    localparam int unsigned FW    = 4 * CHANNELS;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef SND_CAPTURE_INT16_EN
    localparam int unsigned NBYTES   = 2 * CHANNELS;
    localparam logic [7:0]  ENCODING = 8'h03;
`else
    localparam int unsigned NBYTES   = CHANNELS;
    localparam logic [7:0]  ENCODING = 8'h02;
`endif
    localparam logic [31:0]      RATE      = 32'(SAMPLE_RATE);
    localparam logic [7:0]       NCH       = 8'(CHANNELS);
    localparam logic [15:0]      DIV_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(NBYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StHeader, StStream, StDrain} state_e;

    function automatic logic [7:0] hdr_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:                   b = 8'h2E;
            5'd1:                   b = 8'h73;
            5'd2:                   b = 8'h6E;
            5'd3:                   b = 8'h64;
            5'd7:                   b = 8'h20;
            5'd8, 5'd9, 5'd10, 5'd11: b = 8'hFF;
            5'd15:                  b = ENCODING;
            5'd16:                  b = RATE[31:24];
            5'd17:                  b = RATE[23:16];
            5'd18:                  b = RATE[15:8];
            5'd19:                  b = RATE[7:0];
            5'd23:                  b = NCH;
            default:                b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] sample_byte(input logic [FW-1:0] frame, input int unsigned idx);
        logic [15:0] f;
        logic [1:0]  ch;
        logic [7:0]  b;
        f = 16'(frame);
`ifdef SND_CAPTURE_INT16_EN
        ch = 2'(idx >> 1);
        b  = (idx % 2 == 1) ? 8'h00 : {1'b0, f[{ch, 2'b00} +: 4], 3'b000};
`else
        ch = 2'(idx);
        b  = {1'b0, f[{ch, 2'b00} +: 4], 3'b000};
`endif
        return b;
    endfunction

    state_e           state_q, state_d;
    logic [4:0]       hdr_idx_q, hdr_idx_d;
    logic             hdr_abort_q, hdr_abort_d;
    logic             hdr_done_q, hdr_done_d;
    logic [15:0]      div_q, div_d;
    logic             tick_q, tick_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nxt_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      overrun_q, overrun_d;
    logic             xfer, pop, wr_en, full;
    logic [FW-1:0]    mem [FIFO_DEPTH];

    assign nxt_ptr = rd_ptr_q + PTR_W'(1);
    assign full    = (count_q == FULL_CNT);
    assign xfer    = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        hdr_abort_d = hdr_abort_q;
        hdr_done_d  = hdr_done_q;
        div_d       = div_q;
        tick_d      = 1'b0;
        byte_idx_d  = byte_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d     = StHeader;
                    hdr_idx_d   = '0;
                    hdr_abort_d = 1'b0;
                    overrun_d   = '0;
                end
            end
            StHeader: begin
                if (!en) hdr_abort_d = 1'b1;
                if (!out_valid_q) begin
                    out_data_d  = hdr_byte(hdr_idx_q);
                    out_valid_d = 1'b1;
                end else if (xfer) begin
                    if (hdr_idx_q == 5'd31) begin
                        out_valid_d = 1'b0;
                        div_d       = '0;
                        if (hdr_abort_q || !en) begin
                            state_d = StIdle;
                        end else begin
                            state_d    = StStream;
                            hdr_done_d = 1'b1;
                        end
                    end else begin
                        hdr_idx_d  = hdr_idx_q + 5'd1;
                        out_data_d = hdr_byte(hdr_idx_q + 5'd1);
                    end
                end
            end
            StStream, StDrain: begin
                // Head frame stays in the FIFO until its last byte is accepted.
                if (!out_valid_q) begin
                    if (count_q != '0) begin
                        out_data_d  = sample_byte(mem[rd_ptr_q], 0);
                        out_valid_d = 1'b1;
                        byte_idx_d  = '0;
                    end
                end else if (xfer) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        pop = 1'b1;
                        if (count_q > CNT_W'(1)) begin
                            out_data_d = sample_byte(mem[nxt_ptr], 0);
                            byte_idx_d = '0;
                        end else begin
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        out_data_d = sample_byte(mem[rd_ptr_q], int'(byte_idx_q) + 1);
                    end
                end

                if (state_q == StStream) begin
                    if (!en) begin
                        state_d = StDrain;
                    end else begin
                        div_d  = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
                        tick_d = (div_q == DIV_LAST);
                    end
                end else if (count_q == '0 && !out_valid_q) begin
                    state_d    = StIdle;
                    hdr_done_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A pop in the same cycle frees the slot, so a tick into a full FIFO is still accepted.
        wr_en = tick_q && (!full || pop);
        if (tick_q && full && !pop && overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hdr_idx_q   <= '0;
            hdr_abort_q <= 1'b0;
            hdr_done_q  <= 1'b0;
            div_q       <= '0;
            tick_q      <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            byte_idx_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= '0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            hdr_abort_q <= hdr_abort_d;
            hdr_done_q  <= hdr_done_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            byte_idx_q  <= byte_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= ch_data[FW-1:0];
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != StIdle);
    assign hdr_done    = hdr_done_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_snd_capture_sched.sv
// Directed bench for snd_capture_sched: header, frame timing, backpressure, overrun, drain, reset abort.
module tb_snd_capture_sched;

    localparam int unsigned DIV = 8;
`ifdef SND_CAPTURE_INT16_EN
    localparam int NB = 8;
    localparam logic [7:0] ENC = 8'h03;
`else
    localparam int NB = 4;
    localparam logic [7:0] ENC = 8'h02;
`endif
    localparam logic [7:0] HDR [32] = '{
        8'h2E, 8'h73, 8'h6E, 8'h64, 8'h00, 8'h00, 8'h00, 8'h20,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, ENC,
        8'h00, 8'h00, 8'hAC, 8'h44, 8'h00, 8'h00, 8'h00, 8'h04,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] ch_data = '0;
    logic [7:0]  out_data;
    logic        out_valid, busy, hdr_done;
    logic [15:0] overrun_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snd_capture_sched #(.SAMPLE_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ch_data    (ch_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .hdr_done   (hdr_done),
        .overrun_cnt(overrun_cnt)
    );

    function automatic logic [15:0] pat(input int k);
        return {4'(k + 3), 4'(k + 2), 4'(k + 1), 4'(k)};
    endfunction

    function automatic logic [7:0] exp_smp(input logic [15:0] p, input int j);
        int ch;
        logic [3:0] s;
        if (NB == 8) begin
            if (j % 2 == 1) return 8'h00;
            ch = j / 2;
        end else begin
            ch = j;
        end
        s = p[ch*4 +: 4];
        return {1'b0, s, 3'b000};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    // Waits for one accepted byte; while stalled, the presented byte must not move.
    task automatic get_byte(input bit toggle, output logic [7:0] b);
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        b = 'x;
        for (int n = 0; n < 200; n++) begin
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                b = out_data;
                cyc();
                if (toggle) out_ready = ~out_ready;
                return;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            cyc();
            if (toggle) out_ready = ~out_ready;
        end
        timeout("get_byte");
    endtask

    task automatic run_header(input bit full);
        logic [7:0] b;
        for (int i = 0; i < 32; i++) begin
            if (full && i == 31) check("hdr_done_early", hdr_done, 0);
            get_byte(1'b0, b);
            if (full || i < 2 || i == 15) check($sformatf("hdr_byte%0d", i), b, HDR[i]);
        end
        check("hdr_done_set", hdr_done, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            cyc();
            n++;
        end
        if (!out_valid) timeout("wait_valid");
    endtask

    task automatic wait_idle_quiet(input string tag);
        int n = 0;
        int seen = 0;
        while (busy && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        repeat (20) begin
            if (out_valid || busy) seen++;
            cyc();
        end
        check({tag, "_quiet"}, seen, 0);
    endtask

    initial begin
        logic [7:0] b;
        int n;

        #12;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_hdr_done", hdr_done, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_data", out_data, 0);
        rst_n = 1'b1;
        cyc();

        // Header, frame latency/order, backpressure.
        ch_data   = 16'h4321;
        en        = 1'b1;
        out_ready = 1'b1;
        run_header(1'b1);
        check("stream_busy", busy, 1);
        wait_valid(n);
        check("first_byte_latency", n, 10);
        for (int j = 0; j < NB; j++) begin
            get_byte(1'b0, b);
            check($sformatf("frame1_b%0d", j), b, exp_smp(16'h4321, j));
        end
        wait_valid(n);
        check("frame_period_gap", n, 8 - NB);
        for (int j = 0; j < NB; j++) begin
            get_byte(1'b0, b);
            check($sformatf("frame2_b%0d", j), b, exp_smp(16'h4321, j));
        end
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < NB; j++) begin
                get_byte(1'b1, b);
                check($sformatf("bp_f%0d_b%0d", f, j), b, exp_smp(16'h4321, j));
            end
        end
        en        = 1'b0;
        out_ready = 1'b1;
        wait_idle_quiet("s1");
        check("s1_hdr_done_clr", hdr_done, 0);

        // Overrun: 6 ticks with the sink stalled; 4 frames kept, 2 dropped.
        en = 1'b1;
        run_header(1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (c % 8 == 4) ch_data = pat(c / 8 + 1);
            cyc();
        end
        check("overrun_cnt", overrun_cnt, 2);
        check("ovr_held_valid", out_valid, 1);
        check("ovr_held_data", out_data, exp_smp(pat(1), 0));
        en        = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < NB; j++) begin
                get_byte(1'b0, b);
                check($sformatf("ovr_f%0d_b%0d", k, j), b, exp_smp(pat(k), j));
            end
        end
        wait_idle_quiet("ovr");
        check("overrun_kept", overrun_cnt, 2);

        // Drain: en dropped mid-frame with two more frames queued.
        en = 1'b1;
        run_header(1'b0);
        check("overrun_cleared", overrun_cnt, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 26; c++) begin
            if (c % 8 == 4) ch_data = pat(c / 8 + 1);
            cyc();
        end
        out_ready = 1'b1;
        get_byte(1'b0, b);
        check("drain_f1_b0", b, exp_smp(pat(1), 0));
        en = 1'b0;
        for (int j = 1; j < NB; j++) begin
            get_byte(1'b0, b);
            check($sformatf("drain_f1_b%0d", j), b, exp_smp(pat(1), j));
        end
        for (int k = 2; k <= 3; k++) begin
            for (int j = 0; j < NB; j++) begin
                get_byte(1'b0, b);
                check($sformatf("drain_f%0d_b%0d", k, j), b, exp_smp(pat(k), j));
            end
        end
        wait_idle_quiet("drain");

        // Reset abort at header byte 10, then restart; en drop mid-header finishes it.
        en = 1'b1;
        for (int i = 0; i < 10; i++) get_byte(1'b0, b);
        check("abort_b9", b, HDR[9]);
        wait_valid(n);
        check("abort_b10_presented", out_data, HDR[10]);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid_async", out_valid, 0);
        check("abort_busy", busy, 0);
        #1;
        rst_n = 1'b1;
        cyc();
        get_byte(1'b0, b);
        check("restart_b0", b, 8'h2E);
        en = 1'b0;
        get_byte(1'b0, b);
        check("restart_b1", b, 8'h73);
        for (int i = 2; i < 32; i++) get_byte(1'b0, b);
        check("hdr_abort_last", b, HDR[31]);
        wait_idle_quiet("hdr_abort");
        check("hdr_abort_done", hdr_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
